// File: rtl/rc5_key_sequencer_if.sv
// Key byte stream between a key source and the RC5 key sequencer (valid/ready, one byte per transfer).
interface rc5_key_sequencer_if;
    logic [7:0] iByte;
    logic       iByte_valid;
    logic       oByte_ready;

    modport master (output iByte, output iByte_valid, input oByte_ready);
    modport slave  (input iByte, input iByte_valid, output oByte_ready);
endinterface

// File: rtl/rc5_key_sequencer.sv
// Loads a B-byte key into the RC5 core key memory, then issues cipher/decipher starts and tracks done.
// Optional WAIT watchdog enabled by defining RC5_SEQ_TIMEOUT_EN.
module rc5_key_sequencer #(
    parameter int B              = 16,
    parameter int B_LENGTH       = $clog2(B),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    rc5_key_sequencer_if.slave      key_in,
    input  logic                    iGo,
    input  logic                    iMode,
    input  logic                    iKeyClear,
    output logic [7:0]              oKey_sub_i,
    output logic [B_LENGTH-1:0]     oKey_address,
    output logic                    oWen,
    output logic                    oStartCipher,
    output logic                    oStartDecipher,
    input  logic                    iDoneCipher,
    input  logic                    iDoneDecipher,
    output logic                    oKeyValid,
    output logic                    oBusy,
    output logic                    oDone,
    output logic                    oGoRejected,
    output logic                    oTimeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READY, S_START, S_WAIT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [B_LENGTH-1:0]   count_q, count_d;
    logic                  mode_q, mode_d;
    logic                  wen_q, wen_d;
    logic [7:0]            data_q, data_d;
    logic [B_LENGTH-1:0]   addr_q, addr_d;
    logic                  start_cipher_q, start_cipher_d;
    logic                  start_decipher_q, start_decipher_d;
    logic                  done_q, done_d;
    logic                  go_rej_q, go_rej_d;
    logic                  timeout_q, timeout_d;

    logic byte_ready;
    logic transfer;
    logic sel_done;
    logic timeout_hit;

    assign byte_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign transfer   = key_in.iByte_valid && byte_ready;
    // Only the done flag matching the captured mode is ever looked at.
    assign sel_done   = mode_q ? iDoneDecipher : iDoneCipher;

`ifdef RC5_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d      = '0;
        timeout_hit = 1'b0;
        if (state_q == S_WAIT) begin
            tcnt_d      = tcnt_q + TW'(1);
            timeout_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tcnt_q <= '0;
        else     tcnt_q <= tcnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            count_q          <= '0;
            mode_q           <= 1'b0;
            wen_q            <= 1'b0;
            data_q           <= '0;
            addr_q           <= '0;
            start_cipher_q   <= 1'b0;
            start_decipher_q <= 1'b0;
            done_q           <= 1'b0;
            go_rej_q         <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            mode_q           <= mode_d;
            wen_q            <= wen_d;
            data_q           <= data_d;
            addr_q           <= addr_d;
            start_cipher_q   <= start_cipher_d;
            start_decipher_q <= start_decipher_d;
            done_q           <= done_d;
            go_rej_q         <= go_rej_d;
            timeout_q        <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (transfer) begin
                    if (count_q == B_LENGTH'(B - 1)) begin
                        count_d = '0;
                        state_d = S_READY;
                    end else begin
                        count_d = count_q + B_LENGTH'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_READY: begin
                if (iKeyClear) begin
                    state_d = S_IDLE;
                end else if (iGo) begin
                    mode_d  = iMode;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (sel_done)         state_d = S_DONE;
                else if (timeout_hit) state_d = S_READY;
            end
            S_DONE: begin
                // Leave only once the level drops so a held done counts once.
                if (!sel_done) state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        wen_d            = transfer;
        data_d           = transfer ? key_in.iByte : data_q;
        addr_d           = transfer ? count_q : addr_q;
        start_cipher_d   = 1'b0;
        start_decipher_d = 1'b0;
        if ((state_q == S_START) ||
            ((state_q == S_WAIT) && !sel_done && !timeout_hit)) begin
            start_cipher_d   = !mode_q;
            start_decipher_d = mode_q;
        end
        done_d    = (state_q == S_WAIT) && sel_done;
        timeout_d = (state_q == S_WAIT) && !sel_done && timeout_hit;
        go_rej_d  = iGo && (state_q != S_READY);
    end

    assign key_in.oByte_ready = byte_ready;
    assign oKey_sub_i         = data_q;
    assign oKey_address       = addr_q;
    assign oWen               = wen_q;
    assign oStartCipher       = start_cipher_q;
    assign oStartDecipher     = start_decipher_q;
    assign oKeyValid          = (state_q == S_READY) || (state_q == S_START) ||
                                (state_q == S_WAIT)  || (state_q == S_DONE);
    assign oBusy              = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_DONE);
    assign oDone              = done_q;
    assign oGoRejected        = go_rej_q;
    assign oTimeout           = timeout_q;

endmodule
